// File: rtl/pixel_readout_ctrl.sv
// ============================================================================
// Module   : pixel_readout_ctrl
// Purpose  : Frame sequencer (erase/expose/convert/read) with valid/ready
//            readout stream and frame counter. Optional: PIX_TESTPAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_readout_ctrl #(
    parameter int DATA_W    = 8,
    parameter int N_READ    = 4,
    parameter int C_ERASE   = 5,
    parameter int C_EXPOSE  = 255,
    parameter int C_CONVERT = 255,
    parameter int C_READ    = 5,
    localparam int CH_W     = (N_READ > 1) ? $clog2(N_READ) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cont,
    input  logic              test_mode,
    output logic              erase,
    output logic              expose,
    output logic              convert,
    output logic [N_READ-1:0] read,
    output logic              ana_bias_en,
    output logic              ana_ramp_en,
    inout  wire  [DATA_W-1:0] pix_bus,
    output logic [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]   out_chan,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic [15:0]       frame_cnt
);

    localparam int C_MAX_A = (C_ERASE > C_EXPOSE) ? C_ERASE : C_EXPOSE;
    localparam int C_MAX_B = (C_CONVERT > C_READ) ? C_CONVERT : C_READ;
    localparam int C_MAX   = (C_MAX_A > C_MAX_B) ? C_MAX_A : C_MAX_B;
    // Counter is at least DATA_W wide so it can double as the ramp code.
    localparam int PH_W    = ($clog2(C_MAX) > DATA_W) ? $clog2(C_MAX) : DATA_W;

    localparam logic [PH_W-1:0] L_ERASE   = PH_W'(C_ERASE - 1);
    localparam logic [PH_W-1:0] L_EXPOSE  = PH_W'(C_EXPOSE - 1);
    localparam logic [PH_W-1:0] L_CONVERT = PH_W'(C_CONVERT - 1);
    localparam logic [PH_W-1:0] L_READ    = PH_W'(C_READ - 1);
    localparam logic [CH_W-1:0] LAST_K    = CH_W'(N_READ - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ERASE   = 3'd1,
        S_EXPOSE  = 3'd2,
        S_CONVERT = 3'd3,
        S_READ    = 3'd4,
        S_HOLD    = 3'd5
    } state_t;

    state_t            r_state;
    logic [CH_W-1:0]   r_k;
    logic [PH_W-1:0]   r_ph_cnt;
    logic              w_phase_last;
    logic [DATA_W-1:0] w_ramp;
    logic [DATA_W-1:0] w_capture;

    always_comb begin
        w_phase_last = 1'b0;
        case (r_state)
            S_ERASE:   w_phase_last = (r_ph_cnt == L_ERASE);
            S_EXPOSE:  w_phase_last = (r_ph_cnt == L_EXPOSE);
            S_CONVERT: w_phase_last = (r_ph_cnt == L_CONVERT);
            S_READ:    w_phase_last = (r_ph_cnt == L_READ);
            default:   w_phase_last = 1'b0;
        endcase
    end

    assign erase       = (r_state == S_ERASE);
    assign expose      = (r_state == S_EXPOSE);
    assign convert     = (r_state == S_CONVERT);
    assign ana_bias_en = expose;
    assign ana_ramp_en = convert;
    assign busy        = (r_state != S_IDLE);
    assign read        = (r_state == S_READ) ? (N_READ'(1) << r_k) : '0;

    // Phase counter restarts at 0 on CONVERT entry, so it is the ramp code.
    assign w_ramp  = convert ? r_ph_cnt[DATA_W-1:0] : '0;
    assign pix_bus = (|read) ? {DATA_W{1'bz}} : w_ramp;

`ifdef PIX_TESTPAT_EN
    logic [DATA_W-1:0] w_pattern;
    assign w_pattern = DATA_W'({frame_cnt, r_k});
    assign w_capture = test_mode ? w_pattern : pix_bus;
`else
    logic unused_test_mode;
    assign unused_test_mode = test_mode;
    assign w_capture        = pix_bus;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_ph_cnt  <= '0;
            out_data  <= '0;
            out_chan  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            frame_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ph_cnt <= '0;
                    r_k      <= '0;
                    if (start || cont) r_state <= S_ERASE;
                end
                S_ERASE: begin
                    if (w_phase_last) begin
                        r_state  <= S_EXPOSE;
                        r_ph_cnt <= '0;
                    end else begin
                        r_ph_cnt <= r_ph_cnt + 1'b1;
                    end
                end
                S_EXPOSE: begin
                    if (w_phase_last) begin
                        r_state  <= S_CONVERT;
                        r_ph_cnt <= '0;
                    end else begin
                        r_ph_cnt <= r_ph_cnt + 1'b1;
                    end
                end
                S_CONVERT: begin
                    if (w_phase_last) begin
                        r_state  <= S_READ;
                        r_ph_cnt <= '0;
                        r_k      <= '0;
                    end else begin
                        r_ph_cnt <= r_ph_cnt + 1'b1;
                    end
                end
                S_READ: begin
                    if (w_phase_last) begin
                        out_data  <= w_capture;
                        out_chan  <= r_k;
                        out_last  <= (r_k == LAST_K);
                        out_valid <= 1'b1;
                        r_ph_cnt  <= '0;
                        r_state   <= S_HOLD;
                    end else begin
                        r_ph_cnt <= r_ph_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_ph_cnt  <= '0;
                        if (r_k == LAST_K) begin
                            r_k       <= '0;
                            frame_cnt <= frame_cnt + 16'd1;
                            r_state   <= cont ? S_ERASE : S_IDLE;
                        end else begin
                            r_k     <= r_k + 1'b1;
                            r_state <= S_READ;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pixel_readout_ctrl.sv
// ============================================================================
// Module   : tb_pixel_readout_ctrl
// Purpose  : Directed, table-driven bench for pixel_readout_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pixel_readout_ctrl;

    localparam int DATA_W    = 8;
    localparam int N_READ    = 4;
    localparam int C_ERASE   = 5;
    localparam int C_EXPOSE  = 20;
    localparam int C_CONVERT = 255;
    localparam int C_READ    = 3;
    localparam int FRAME_LEN = C_ERASE + C_EXPOSE + C_CONVERT + N_READ * (C_READ + 1);

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        cont = 1'b0;
    logic        test_mode = 1'b0;
    logic        out_ready = 1'b1;
    logic        erase, expose, convert, ana_bias_en, ana_ramp_en;
    logic        out_valid, out_last, busy;
    logic [3:0]  read;
    logic [7:0]  out_data;
    logic [1:0]  out_chan;
    logic [15:0] frame_cnt;
    wire  [7:0]  pix_bus;

    // Pixel array model: drives the selected group's value while a read line is high.
    logic [7:0] pix_val [4];
    logic [7:0] model_drv;
    always_comb begin
        model_drv = '0;
        for (int g = 0; g < 4; g++) if (read[g]) model_drv = pix_val[g];
    end
    assign pix_bus = (|read) ? model_drv : 8'bz;

    always #5 clk = ~clk;

    pixel_readout_ctrl #(
        .DATA_W(DATA_W), .N_READ(N_READ), .C_ERASE(C_ERASE),
        .C_EXPOSE(C_EXPOSE), .C_CONVERT(C_CONVERT), .C_READ(C_READ)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cont(cont), .test_mode(test_mode),
        .erase(erase), .expose(expose), .convert(convert), .read(read),
        .ana_bias_en(ana_bias_en), .ana_ramp_en(ana_ramp_en), .pix_bus(pix_bus),
        .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .frame_cnt(frame_cnt)
    );

    typedef struct {
        logic [7:0] bus;
        logic [7:0] exp_data;
        int         stall;
    } word_t;

    word_t       tbl [16];
    int          checks = 0;
    int          errors = 0;
    int          busy_n = 0;
    logic [15:0] exp_fc = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic adv();
        if (busy) busy_n++;
        tick();
    endtask

    function automatic logic [8:0] ph();
        return {erase, expose, convert, ana_bias_en, ana_ramp_en, read};
    endfunction

    function automatic logic [37:0] all_out();
        return {ph(), out_valid, out_last, busy, out_data, out_chan, frame_cnt};
    endfunction

    // Entered on the first ERASE sample; leaves on the sample after the final accept.
    task automatic run_frame(input int f, input logic cont_after);
        int stall_tot = 0;
        busy_n = 0;
        for (int g = 0; g < 4; g++) pix_val[g] = tbl[f*4+g].bus;
        for (int i = 0; i < C_ERASE; i++) begin
            chk("erase_phase", ph(), 9'h100);
            adv();
        end
        if (!cont_after) cont = 1'b0;
        for (int i = 0; i < C_EXPOSE; i++) begin
            chk("expose_phase", ph(), 9'h0A0);
            adv();
        end
        for (int i = 0; i < C_CONVERT; i++) begin
            chk("convert_phase", ph(), 9'h050);
            chk("ramp_code", pix_bus, 64'(i));
            adv();
        end
        for (int g = 0; g < 4; g++) begin
            for (int r = 0; r < C_READ; r++) begin
                chk("read_phase", ph(), 64'(1 << g));
                adv();
            end
            chk("hold_valid", out_valid, 1);
            chk("hold_phase", ph(), 0);
            chk("out_data", out_data, tbl[f*4+g].exp_data);
            chk("out_chan", out_chan, 64'(g));
            chk("out_last", out_last, (g == 3) ? 1 : 0);
            if (tbl[f*4+g].stall > 0) begin
                out_ready = 1'b0;
                for (int s = 0; s < tbl[f*4+g].stall; s++) begin
                    adv();
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", out_data, tbl[f*4+g].exp_data);
                    chk("stall_read", read, 0);
                end
                out_ready = 1'b1;
                stall_tot += tbl[f*4+g].stall;
            end
            adv();
            chk("valid_after_accept", out_valid, 0);
        end
        exp_fc++;
        chk("frame_cnt", frame_cnt, exp_fc);
        chk("busy_cycles", 64'(busy_n), 64'(FRAME_LEN + stall_tot));
        chk("erase_after_last", erase, cont_after);
        chk("busy_after_last", busy, cont_after);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [7:0] bv [16];
        logic       found;
        bv = '{8'hA5, 8'h3C, 8'h7E, 8'hFF,  8'hA5, 8'h3C, 8'h7E, 8'hFF,
               8'h12, 8'h34, 8'h56, 8'h78,  8'h9A, 8'hBC, 8'hDE, 8'hF0};
        for (int i = 0; i < 16; i++) begin
            tbl[i].bus      = bv[i];
            tbl[i].exp_data = bv[i];
            tbl[i].stall    = 0;
        end
        tbl[5].stall = 10;
`ifdef PIX_TESTPAT_EN
        // Continuous frames run with test_mode=1: {frame_cnt[5:0], k}.
        for (int g = 0; g < 4; g++) begin
            tbl[8+g].exp_data  = 8'(g);
            tbl[12+g].exp_data = 8'(4 + g);
        end
`endif
        for (int g = 0; g < 4; g++) pix_val[g] = '0;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", all_out(), 0);
        chk("reset_bus", pix_bus, 0);
        reset = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("idle_outputs", all_out(), 0);
        end
        chk("idle_bus", pix_bus, 0);

        // Abort mid-CONVERT at ramp code 100
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (convert && pix_bus == 8'd100) found = 1'b1;
            else tick();
        end
        chk("reach_ramp100", found, 1);
        reset = 1'b0;
        #1;
        chk("abort_outputs", all_out(), 0);
        chk("abort_bus", pix_bus, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        chk("after_abort_idle", all_out(), 0);

        // Normal frame after abort
        start = 1'b1;
        tick();
        start = 1'b0;
        run_frame(0, 1'b0);

        // Backpressure on group 1; start while busy must be ignored
        tick();
        start = 1'b1;
        tick();
        run_frame(1, 1'b0);
        start = 1'b0;
        tick();
        chk("idle_after_bp", busy, 0);

        // Continuous frames from a fresh reset; cont cleared during the second
        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp_fc    = '0;
        test_mode = 1'b1;
        cont      = 1'b1;
        tick();
        run_frame(2, 1'b1);
        run_frame(3, 1'b0);
        test_mode = 1'b0;
        tick();
        chk("idle_after_cont", busy, 0);
        chk("final_frame_cnt", frame_cnt, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
